// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signals of the memory arbiter, bundled for port connection.
// slave = arbiter side, master = requesters/RAM side.
interface mem_arbiter_if;
    logic        rdy;
    logic        clear;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_data;
    logic        lsb_req;
    logic [31:0] lsb_addr;
    logic [2:0]  lsb_size;
    logic        lsb_done;
    logic [31:0] lsb_data;
    logic        rob_req;
    logic        rob_wr;
    logic [31:0] rob_addr;
    logic [2:0]  rob_size;
    logic [31:0] rob_wdata;
    logic        rob_done;
    logic [31:0] rob_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    // Handshake: each *_req is a level held until its one-cycle *_done; the requester drops it on done.
    modport slave (
        input  rdy, clear, if_req, if_addr, lsb_req, lsb_addr, lsb_size,
               rob_req, rob_wr, rob_addr, rob_size, rob_wdata, mem_din, io_buffer_full,
        output if_done, if_data, lsb_done, lsb_data, rob_done, rob_rdata,
               mem_dout, mem_a, mem_wr
    );

    modport master (
        output rdy, clear, if_req, if_addr, lsb_req, lsb_addr, lsb_size,
               rob_req, rob_wr, rob_addr, rob_size, rob_wdata, mem_din, io_buffer_full,
        input  if_done, if_data, lsb_done, lsb_data, rob_done, rob_rdata,
               mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_arbiter.sv
// Byte-wide RAM/IO bus arbiter for ROB > LSB > IF; splits requests into 1/2/4 byte cycles.
// RAM is synchronous: byte k addressed in BUSY cycle k arrives on mem_din one cycle later.
module mem_arbiter #(
    parameter logic [31:0] IO_BASE = 32'h30000
) (
    input  logic          clk,
    input  logic          rst,
    mem_arbiter_if.slave  arb,
    output logic [1:0]    o_dbg_state
);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_BUSY = 2'd1, ST_DONE = 2'd2} state_t;
    typedef enum logic [1:0] {PORT_IF = 2'd0, PORT_LSB = 2'd1, PORT_ROB = 2'd2} port_t;

    state_t      r_state;
    state_t      w_state_next;
    port_t       r_port;
    port_t       w_grant_port;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_data;
    logic [2:0]  r_size;
    logic [2:0]  r_cnt;
    logic        r_wr;

    logic        w_grant;
    logic [31:0] w_req_addr;
    logic [31:0] w_req_wdata;
    logic [2:0]  w_req_size;
    logic        w_req_wr;
    logic [31:0] w_byte_addr;
    logic        w_is_io;
    logic        w_stall;
    logic        w_abort;
    logic        w_xfer_end;
    logic [7:0]  w_wbyte;

    function automatic logic [2:0] norm_size(input logic [2:0] s);
        if (s == 3'd0)
            return 3'd1;
        else if (s > 3'd4)
            return 3'd4;
        else
            return s;
    endfunction

    // Clear hides LSB/IF requests for the cycle; ROB requests are committed work.
    always_comb begin
        w_grant      = 1'b0;
        w_grant_port = PORT_IF;
        w_req_addr   = arb.if_addr;
        w_req_size   = 3'd4;
        w_req_wdata  = 32'd0;
        w_req_wr     = 1'b0;
        if (arb.rob_req) begin
            w_grant      = 1'b1;
            w_grant_port = PORT_ROB;
            w_req_addr   = arb.rob_addr;
            w_req_size   = norm_size(arb.rob_size);
            w_req_wdata  = arb.rob_wdata;
            w_req_wr     = arb.rob_wr;
        end else if (!arb.clear && arb.lsb_req) begin
            w_grant      = 1'b1;
            w_grant_port = PORT_LSB;
            w_req_addr   = arb.lsb_addr;
            w_req_size   = norm_size(arb.lsb_size);
        end else if (!arb.clear && arb.if_req) begin
            w_grant      = 1'b1;
        end
    end

    assign w_byte_addr = r_addr + {29'd0, r_cnt};
    assign w_is_io     = (w_byte_addr[17:16] == IO_BASE[17:16]);
    assign w_stall     = r_wr && w_is_io && arb.io_buffer_full;
    assign w_abort     = arb.clear && (r_port != PORT_ROB);
    // Reads need one extra cycle to catch the last byte coming back from the RAM.
    assign w_xfer_end  = r_wr ? (!w_stall && (r_cnt == r_size - 3'd1)) : (r_cnt == r_size);

    always_comb begin
        case (r_cnt[1:0])
            2'd0:    w_wbyte = r_wdata[7:0];
            2'd1:    w_wbyte = r_wdata[15:8];
            2'd2:    w_wbyte = r_wdata[23:16];
            default: w_wbyte = r_wdata[31:24];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_state <= ST_IDLE;
        else if (arb.rdy)
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_grant) w_state_next = ST_BUSY;
            ST_BUSY: begin
                if (w_abort)
                    w_state_next = ST_IDLE;
                else if (w_xfer_end)
                    w_state_next = ST_DONE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_port  <= PORT_IF;
            r_addr  <= 32'd0;
            r_wdata <= 32'd0;
            r_data  <= 32'd0;
            r_size  <= 3'd0;
            r_cnt   <= 3'd0;
            r_wr    <= 1'b0;
        end else if (arb.rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_port  <= w_grant_port;
                        r_addr  <= w_req_addr;
                        r_size  <= w_req_size;
                        r_wdata <= w_req_wdata;
                        r_wr    <= w_req_wr;
                        r_cnt   <= 3'd0;
                        r_data  <= 32'd0;
                    end
                end
                ST_BUSY: begin
                    if (!r_wr) begin
                        case (r_cnt)
                            3'd1:    r_data[7:0]   <= arb.mem_din;
                            3'd2:    r_data[15:8]  <= arb.mem_din;
                            3'd3:    r_data[23:16] <= arb.mem_din;
                            3'd4:    r_data[31:24] <= arb.mem_din;
                            default: ;
                        endcase
                        if (r_cnt != r_size)
                            r_cnt <= r_cnt + 3'd1;
                    end else if (!w_stall) begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        arb.mem_a    = 32'd0;
        arb.mem_dout = 8'd0;
        arb.mem_wr   = 1'b0;
        arb.if_done  = 1'b0;
        arb.lsb_done = 1'b0;
        arb.rob_done = 1'b0;
        case (r_state)
            ST_BUSY: begin
                if (r_wr) begin
                    arb.mem_a    = w_byte_addr;
                    arb.mem_dout = w_wbyte;
                    arb.mem_wr   = arb.rdy && !w_stall && !w_abort;
                end else if (r_cnt != r_size) begin
                    arb.mem_a = w_byte_addr;
                end
            end
            ST_DONE: begin
                if (arb.rdy && !w_abort) begin
                    case (r_port)
                        PORT_ROB: arb.rob_done = 1'b1;
                        PORT_LSB: arb.lsb_done = 1'b1;
                        default:  arb.if_done  = 1'b1;
                    endcase
                end
            end
            default: ;
        endcase
    end

    assign arb.if_data   = r_data;
    assign arb.lsb_data  = r_data;
    assign arb.rob_rdata = r_data;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: synchronous RAM model, done/write scoreboards, summary line.
module tb_mem_arbiter;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    mem_arbiter_if bus();

    mem_arbiter #(.IO_BASE(32'h30000)) dut (
        .clk         (clk),
        .rst         (rst),
        .arb         (bus),
        .o_dbg_state (dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // exp_q entry: {check_data, port(0=IF,1=LSB,2=ROB), data}; wr_q entry: {addr, byte}
    logic [34:0] exp_q[$];
    logic [39:0] wr_q[$];
    logic [7:0]  ram [0:1023];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.mem_wr)
            ram[bus.mem_a[9:0]] <= bus.mem_dout;
        bus.mem_din <= ram[bus.mem_a[9:0]];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req_v);
        checks++;
        if (act !== req_v) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req_v);
        end
    endtask

    task automatic mon_done(input logic [1:0] p, input logic [31:0] d);
        logic [34:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL done_unexpected actual=port%0d required=none", p);
        end else begin
            e = exp_q.pop_front();
            chk("done_port", {62'd0, p}, {62'd0, e[33:32]});
            if (e[34])
                chk("done_data", {32'd0, d}, {32'd0, e[31:0]});
        end
    endtask

    task automatic mon_wr(input logic [31:0] a, input logic [7:0] b);
        logic [39:0] e;
        if (wr_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL wr_unexpected actual=%h:%h required=none", a, b);
        end else begin
            e = wr_q.pop_front();
            chk("wr_addr_byte", {24'd0, a, b}, {24'd0, e});
        end
    endtask

    always @(negedge clk) begin
        if (bus.if_done)  mon_done(2'd0, bus.if_data);
        if (bus.lsb_done) mon_done(2'd1, bus.lsb_data);
        if (bus.rob_done) mon_done(2'd2, bus.rob_rdata);
        if (bus.mem_wr)   mon_wr(bus.mem_a, bus.mem_dout);
    end

    function automatic logic done_of(input int p);
        case (p)
            0:       return bus.if_done;
            1:       return bus.lsb_done;
            default: return bus.rob_done;
        endcase
    endfunction

    task automatic wait_done(input int p, input int budget, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!done_of(p) && n < budget);
        if (!done_of(p)) begin
            checks++;
            failures++;
            $display("FAIL done_timeout actual=no_done required=port%0d_done", p);
        end
    endtask

    task automatic issue_if(input logic [31:0] a);
        bus.if_addr = a;
        bus.if_req  = 1'b1;
    endtask

    task automatic issue_lsb(input logic [31:0] a, input logic [2:0] s);
        bus.lsb_addr = a;
        bus.lsb_size = s;
        bus.lsb_req  = 1'b1;
    endtask

    task automatic issue_rob(input logic wr, input logic [31:0] a, input logic [2:0] s, input logic [31:0] d);
        bus.rob_wr    = wr;
        bus.rob_addr  = a;
        bus.rob_size  = s;
        bus.rob_wdata = d;
        bus.rob_req   = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b0;
        bus.rdy = 1'b1;
        bus.clear = 1'b0;
        bus.if_req = 1'b0;
        bus.if_addr = 32'd0;
        bus.lsb_req = 1'b0;
        bus.lsb_addr = 32'd0;
        bus.lsb_size = 3'd0;
        bus.rob_req = 1'b0;
        bus.rob_wr = 1'b0;
        bus.rob_addr = 32'd0;
        bus.rob_size = 3'd0;
        bus.rob_wdata = 32'd0;
        bus.io_buffer_full = 1'b0;
        for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
        ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
        ram[10'h201] = 8'hA5; ram[10'h202] = 8'h5A;

        // Reset values
        #2 rst = 1'b1;
        #1;
        chk("rst_state", {62'd0, dbg_state}, 64'd0);
        chk("rst_mem_a", {32'd0, bus.mem_a}, 64'd0);
        chk("rst_mem_wr", {63'd0, bus.mem_wr}, 64'd0);
        chk("rst_if_data", {32'd0, bus.if_data}, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1: 4-byte fetch, address walk and latency
        @(negedge clk);
        issue_if(32'h100);
        exp_q.push_back({1'b1, 2'd0, 32'h44332211});
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("t1_mem_a", {32'd0, bus.mem_a}, {32'd0, 32'h100 + k});
        end
        wait_done(0, 10, n);
        bus.if_req = 1'b0;
        chk("t1_latency", n, 2);

        // 2: LSB beats IF, IF follows after DONE
        @(negedge clk);
        issue_lsb(32'h201, 3'd2);
        issue_if(32'h100);
        exp_q.push_back({1'b1, 2'd1, 32'h00005AA5});
        exp_q.push_back({1'b1, 2'd0, 32'h44332211});
        wait_done(1, 10, n);
        bus.lsb_req = 1'b0;
        chk("t2_lsb_latency", n, 4);
        wait_done(0, 12, n);
        bus.if_req = 1'b0;
        chk("t2_if_latency", n, 7);

        // 3: 4-byte store, then load it back
        @(negedge clk);
        issue_rob(1'b1, 32'h300, 3'd4, 32'hDEADBEEF);
        wr_q.push_back({32'h300, 8'hEF});
        wr_q.push_back({32'h301, 8'hBE});
        wr_q.push_back({32'h302, 8'hAD});
        wr_q.push_back({32'h303, 8'hDE});
        exp_q.push_back({1'b0, 2'd2, 32'd0});
        wait_done(2, 10, n);
        bus.rob_req = 1'b0;
        chk("t3_store_latency", n, 5);
        @(negedge clk);
        issue_lsb(32'h300, 3'd4);
        exp_q.push_back({1'b1, 2'd1, 32'hDEADBEEF});
        wait_done(1, 10, n);
        bus.lsb_req = 1'b0;
        chk("t3_load_latency", n, 6);

        // 4: IO write stalled by a full UART buffer for 3 cycles
        @(negedge clk);
        bus.io_buffer_full = 1'b1;
        issue_rob(1'b1, 32'h30000, 3'd1, 32'h00000041);
        wr_q.push_back({32'h30000, 8'h41});
        exp_q.push_back({1'b0, 2'd2, 32'd0});
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t4_stall_wr", {63'd0, bus.mem_wr}, 64'd0);
        end
        @(posedge clk);
        #1 bus.io_buffer_full = 1'b0;
        wait_done(2, 10, n);
        bus.rob_req = 1'b0;
        chk("t4_latency", n, 2);

        // 5: clear aborts a fetch at byte 2; pending ROB store goes next
        @(negedge clk);
        issue_if(32'h100);
        exp_q.push_back({1'b0, 2'd2, 32'd0});
        wr_q.push_back({32'h310, 8'h77});
        repeat (3) @(negedge clk);
        chk("t5_mem_a", {32'd0, bus.mem_a}, {32'd0, 32'h102});
        bus.clear = 1'b1;
        bus.if_req = 1'b0;
        issue_rob(1'b1, 32'h310, 3'd1, 32'h00000077);
        @(negedge clk);
        bus.clear = 1'b0;
        chk("t5_idle", {62'd0, dbg_state}, 64'd0);
        wait_done(2, 10, n);
        bus.rob_req = 1'b0;
        chk("t5_rob_latency", n, 2);

        // 6: async reset mid-store, clean restart
        @(negedge clk);
        issue_rob(1'b1, 32'h320, 3'd4, 32'h01020304);
        wr_q.push_back({32'h320, 8'h04});
        wr_q.push_back({32'h321, 8'h03});
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        bus.rob_req = 1'b0;
        #1;
        chk("t6_mem_wr", {63'd0, bus.mem_wr}, 64'd0);
        chk("t6_mem_a", {32'd0, bus.mem_a}, 64'd0);
        chk("t6_mem_dout", {56'd0, bus.mem_dout}, 64'd0);
        chk("t6_state", {62'd0, dbg_state}, 64'd0);
        chk("t6_lsb_data", {32'd0, bus.lsb_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue_lsb(32'h320, 3'd2);
        exp_q.push_back({1'b1, 2'd1, 32'h00000304});
        wait_done(1, 10, n);
        bus.lsb_req = 1'b0;
        chk("t6_load_latency", n, 4);

        // 7: rdy low freezes a 1-byte load
        @(negedge clk);
        issue_lsb(32'h100, 3'd1);
        exp_q.push_back({1'b1, 2'd1, 32'h00000011});
        @(negedge clk);
        bus.rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("t7_frozen_state", {62'd0, dbg_state}, 64'd1);
        end
        bus.rdy = 1'b1;
        wait_done(1, 10, n);
        bus.lsb_req = 1'b0;
        chk("t7_latency", n, 2);

        repeat (3) @(negedge clk);
        chk("exp_q_drained", exp_q.size(), 0);
        chk("wr_q_drained", wr_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
